// File: rtl/cpu_pkg.sv
// Shared CPU-side constants: default bus widths, owner encoding and small helpers.
package cpu_pkg;

  // Default widths, shared with the CPU core.
  localparam int unsigned DEF_AW = 8;
  localparam int unsigned DEF_DW = 16;

  // Width of the fetch starvation counter.
  localparam int unsigned WAIT_CW = 4;

  // Tag for the memory access that is currently in flight.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  // Increment that sticks at the all-ones value.
  function automatic logic [WAIT_CW-1:0] sat_inc(input logic [WAIT_CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/starve_counter.sv
// Counts consecutive cycles in which fetch asks but is refused, and flags when
// fetch has waited long enough to take priority over data.
module starve_counter
  import cpu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_req_i,
  input  logic if_gnt_i,
  output logic starve_o
);

  localparam logic [WAIT_CW-1:0] Thresh = WAIT_CW'(MAX_WAIT);

  logic [WAIT_CW-1:0] cnt_q, cnt_d;

  // Next count: grow while refused, clear on service or withdrawal.
  always_comb begin
    cnt_d = '0;
    if (if_req_i && !if_gnt_i) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  // Counter state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve_o = (cnt_q >= Thresh);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and the
// load/store path. Data wins ties unless fetch has been starved too long; read
// data is steered back to whichever requester issued the access.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic       starve;
  logic [1:0] owner_q, owner_d;

  starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_counter (
    .clk_i    (clk),
    .rst_i    (rst),
    .if_req_i (if_req),
    .if_gnt_i (if_gnt),
    .starve_o (starve)
  );

  // Grant selection; everything is held low while reset is asserted.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      if (if_req && d_req) begin
        if_gnt = starve;
        d_gnt  = !starve;
      end else begin
        if_gnt = if_req;
        d_gnt  = d_req;
      end
    end
  end

  // Memory command taken from whichever side was granted.
  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // Remember who owns the read in flight; stores return nothing.
  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_D;
    end
  end

  // Owner tag and registered response path; rdata holds between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OWN_NONE;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      owner_q   <= owner_d;
      if_rvalid <= (owner_q == OWN_IF);
      d_rvalid  <= (owner_q == OWN_D);
      if (owner_q == OWN_IF) begin
        if_rdata <= mem_rdata;
      end
      if (owner_q == OWN_D) begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: a reference arbiter and shadow memory predict grants and
// read data; expected responses queue up at grant time and are matched on rvalid.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned MW = 3;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  mem_port_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .MAX_WAIT (MW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory actually driven by the DUT, and the bench's own shadow copy.
  logic [DW-1:0] mem  [256];
  logic [DW-1:0] refm [256];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          q_if[$];
  exp_t          q_d[$];
  exp_t          e;
  int            cyc    = 0;
  logic [3:0]    wcnt_m = '0;
  logic          ig_m, dg_m;
  logic [DW-1:0] last_if = '0;
  logic [DW-1:0] last_d  = '0;

  // Reference model and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    // Responses due now.
    if (if_rvalid) begin
      if (q_if.size() == 0) begin
        check_val("if_rvalid_extra", 32'(1), 32'(0));
      end else begin
        e = q_if.pop_front();
        check_val("if_rdata", 32'(if_rdata), 32'(e.data));
        check_val("if_latency", 32'(cyc - e.cyc), 32'(2));
        last_if = e.data;
      end
    end else begin
      check_val("if_rdata_hold", 32'(if_rdata), 32'(last_if));
      if (q_if.size() > 0 && cyc - q_if[0].cyc >= 2) begin
        check_val("if_rvalid_missing", 32'(0), 32'(1));
        void'(q_if.pop_front());
      end
    end
    if (d_rvalid) begin
      if (q_d.size() == 0) begin
        check_val("d_rvalid_extra", 32'(1), 32'(0));
      end else begin
        e = q_d.pop_front();
        check_val("d_rdata", 32'(d_rdata), 32'(e.data));
        check_val("d_latency", 32'(cyc - e.cyc), 32'(2));
        last_d = e.data;
      end
    end else begin
      check_val("d_rdata_hold", 32'(d_rdata), 32'(last_d));
      if (q_d.size() > 0 && cyc - q_d[0].cyc >= 2) begin
        check_val("d_rvalid_missing", 32'(0), 32'(1));
        void'(q_d.pop_front());
      end
    end
    check_val("rvalid_excl", 32'(if_rvalid & d_rvalid), 32'(0));

    // Expected arbitration.
    if (rst) begin
      ig_m = 1'b0;
      dg_m = 1'b0;
    end else if (if_req && d_req) begin
      ig_m = (wcnt_m >= 4'(MW));
      dg_m = !ig_m;
    end else begin
      ig_m = if_req;
      dg_m = d_req;
    end
    check_val("if_gnt", 32'(if_gnt), 32'(ig_m));
    check_val("d_gnt", 32'(d_gnt), 32'(dg_m));
    check_val("mem_en", 32'(mem_en), 32'(ig_m | dg_m));
    check_val("mem_we", 32'(mem_we), 32'(dg_m & d_we));
    if (ig_m | dg_m) begin
      check_val("mem_addr", 32'(mem_addr), dg_m ? 32'(d_addr) : 32'(if_addr));
      check_val("mem_wdata", 32'(mem_wdata), dg_m ? 32'(d_wdata) : 32'(0));
    end

    // Predicted read data from the shadow memory.
    if (ig_m) q_if.push_back('{data: refm[if_addr], cyc: cyc});
    if (dg_m && !d_we) q_d.push_back('{data: refm[d_addr], cyc: cyc});
    if (dg_m && d_we) refm[d_addr] = d_wdata;

    if (rst) wcnt_m = '0;
    else if (if_req && !ig_m) wcnt_m = (wcnt_m == 4'hF) ? wcnt_m : wcnt_m + 4'd1;
    else wcnt_m = '0;

    // A reset edge kills anything still in flight and zeroes rdata.
    if (rst) begin
      q_if.delete();
      q_d.delete();
      last_if = '0;
      last_d  = '0;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 16'(i * 16'h0101) ^ 16'hA5C3;
      refm[i] = 16'(i * 16'h0101) ^ 16'hA5C3;
    end
    mem[8'h10] = 16'h1234; refm[8'h10] = 16'h1234;
    mem[8'h20] = 16'hBEEF; refm[8'h20] = 16'hBEEF;

    // Reset with both requests up: nothing may be granted.
    rst = 1'b1;
    if_req = 1'b1; if_addr = 8'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20; d_wdata = '0;
    step();
    step();
    rst = 1'b0;

    // Fetch alone.
    d_req = 1'b0;
    if_addr = 8'h10;
    step();
    idle();
    repeat (3) step();

    // Sustained contention: fetch must win every fourth slot.
    if_req = 1'b1; if_addr = 8'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    repeat (12) step();
    idle();
    repeat (3) step();

    // Store then load to the same word.
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h30; d_wdata = 16'h5A5A;
    step();
    d_we = 1'b0;
    step();
    idle();
    repeat (3) step();

    // Alternating fetch / load / fetch, back to back.
    if_req = 1'b1; if_addr = 8'h00;
    step();
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h01;
    step();
    d_req = 1'b0; if_req = 1'b1; if_addr = 8'h02;
    step();
    idle();
    repeat (3) step();

    // Reset right behind a granted load.
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 8'h10;
    step();
    idle();
    repeat (3) step();

    // Fetch withdrawn while data hogs the port.
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    if_req = 1'b1; if_addr = 8'h50;
    step();
    step();
    if_req = 1'b0;
    repeat (4) step();
    idle();
    repeat (3) step();

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      if_req  = 1'($urandom_range(0, 1));
      if_addr = 8'($urandom_range(0, 15));
      d_req   = 1'($urandom_range(0, 1));
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = 8'($urandom_range(0, 15));
      d_wdata = 16'($urandom);
      step();
    end
    idle();
    repeat (4) step();

    check_val("if_queue_drained", 32'(q_if.size()), 32'(0));
    check_val("d_queue_drained", 32'(q_d.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous 16-bit memory between the CPU instruction-fetch path and the load/store data path.
- Grants at most one access per cycle and routes the read data back to the requester that owned that access.
- Default priority goes to data accesses; fetch is protected from starvation by a wait counter.
- Sits between the CPU core and the unified instruction/data memory.

Parameters:
- AW, 8, memory word-address width
- DW, 16, data/instruction width
- MAX_WAIT, 3, consecutive denied fetch cycles after which fetch wins the next arbitration (1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  AW  fetch word address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch data valid (registered)
- if_rdata  out  DW  fetched instruction
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data word address
- d_wdata  in  DW  store data
- d_gnt  out  1  data access accepted this cycle (combinational)
- d_rvalid  out  1  load data valid (registered; never asserted for stores)
- d_rdata  out  DW  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset (rst=1 at a clk edge):
  - owner := NONE; wait_cnt := 0; if_rvalid := 0; d_rvalid := 0; if_rdata := 0; d_rdata := 0.
  - Combinational outputs are forced to 0 while rst=1.
  - A read issued in the cycle before reset never produces rvalid.
- Arbitration (combinational, each cycle rst=0):
  - Neither request: no grant; mem_en=0.
  - Only one request: that requester is granted.
  - Both requests: data wins unless wait_cnt >= MAX_WAIT, in which case fetch wins.
  - Exactly one gnt at most; mem_en equals the OR of the grants.
  - mem_we = d_gnt & d_we; mem_addr and mem_wdata are taken from the granted requester; mem_wdata = 0 on a fetch.
- Wait counter (4-bit):
  - Increments, saturating at 15, when if_req=1 and if_gnt=0.
  - Clears to 0 on if_gnt or when if_req=0.
- Owner register, states NONE / IF / D:
  - Next owner = IF if if_gnt; D if d_gnt & ~d_we; else NONE.
  - Stores produce no owner.
- Response routing:
  - In the cycle after a granted read, if owner=IF then if_rvalid=1 and if_rdata=mem_rdata, latched on that edge.
  - Same for D with d_rvalid and d_rdata.
  - rdata holds its last value when rvalid=0.
- Latency: grant in cycle N; rvalid and rdata are registered at the edge ending cycle N+1, one cycle after mem_rdata becomes valid. Total load-to-use latency is 2 cycles.
- Back-to-back: a new grant may be issued in the same cycle a previous read's data returns. Full throughput is 1 access per cycle.
- Same address, store then load on consecutive grants: the load returns the stored value (memory ordering preserved, no reordering).
- A requester dropping req before gnt is legal; no access occurs.

Decomposition:
- Shared package `cpu_pkg`:
  - Owner encoding constants: OWN_NONE=2'd0, OWN_IF=2'd1, OWN_D=2'd2.
  - Default AW/DW values, shared with the CPU core.
- One sub-module, `starve_counter`: the saturating wait counter with threshold compare output. Everything else stays flat.

Test Plan:
- Reset: assert rst for 2 cycles with if_req=d_req=1 -> all gnt, rvalid and mem_en are 0; after release with memory preloaded [0x10]=0x1234, fetch-only at 0x10 -> if_gnt same cycle, if_rvalid=1 with if_rdata=0x1234 two edges later.
- Contention: if_req and d_req (load 0x20=0xBEEF) held high continuously with MAX_WAIT=3 -> grants D,D,D,IF,D,D,D,IF…; every d_rvalid carries 0xBEEF and no fetch is starved longer than 3 cycles.
- Store/load ordering: d store 0x5A5A to 0x30, next cycle d load 0x30 -> mem_we=1 then 0; d_rvalid=1 with 0x5A5A; no d_rvalid for the store.
- Alternating back-to-back: fetch 0x00, load 0x01, fetch 0x02 on consecutive cycles -> responses in order, if_rvalid/d_rvalid never both high, each carrying its own address's data.
- Reset mid-operation: grant a load, assert rst in the next cycle -> d_rvalid stays 0 and owner is NONE; after release, the first new request is served normally.
- Request withdrawal: if_req high 2 cycles under data contention, then dropped -> wait_cnt clears and no fetch access appears on mem_en.
